cfg_cmd_scheduler: RTL

Arbitrates and sequences CPU command transactions from two requesters (N64 PI side and USB side) into the single config command mailbox: command byte, two 32-bit data words, the `cmd_request` strobe, and the `cpu_busy` handshake. The block loads data registers, fires the request, and tracks the CPU's busy flag to completion or timeout. It then returns the two response data words to the granted requester. It sits between the requester front-ends and the config register block.

---
 rtl/cfg_cmd_scheduler_if.sv | 47 ++++
 rtl/cfg_cmd_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_cmd_scheduler_if.sv
// Signal bundle between cfg_cmd_scheduler, its two requester front-ends and the config mailbox.
// The master modport is the scheduler itself; the slave modport is the surrounding logic.
interface cfg_cmd_scheduler_if;
  logic        n64_req;
  logic [7:0]  n64_cmd;
  logic [63:0] n64_wdata;
  logic        n64_ack;
  logic        n64_error;
  logic [63:0] n64_rdata;

  logic        usb_req;
  logic [7:0]  usb_cmd;
  logic [63:0] usb_wdata;
  logic        usb_ack;
  logic        usb_error;
  logic [63:0] usb_rdata;

  logic [7:0]  cmd;
  logic [31:0] wdata;
  logic [1:0]  data_write;
  logic        cmd_request;
  logic        cpu_ready;
  logic        cpu_busy;
  logic [31:0] data_0;
  logic [31:0] data_1;
  logic        busy;

  modport master (
    input  n64_req, n64_cmd, n64_wdata,
    output n64_ack, n64_error, n64_rdata,
    input  usb_req, usb_cmd, usb_wdata,
    output usb_ack, usb_error, usb_rdata,
    output cmd, wdata, data_write, cmd_request,
    input  cpu_ready, cpu_busy, data_0, data_1,
    output busy
  );

  modport slave (
    output n64_req, n64_cmd, n64_wdata,
    input  n64_ack, n64_error, n64_rdata,
    output usb_req, usb_cmd, usb_wdata,
    input  usb_ack, usb_error, usb_rdata,
    input  cmd, wdata, data_write, cmd_request,
    output cpu_ready, cpu_busy, data_0, data_1,
    input  busy
  );
endinterface

// File: rtl/cfg_cmd_scheduler.sv
// Two-requester (N64 / USB) command scheduler for the config mailbox: round-robin grant,
// data-register load, command strobe, busy handshake with timeout, and response return.
module cfg_cmd_scheduler #(
  parameter int unsigned          TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  cfg_cmd_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOAD_0      = 3'd1,
    ST_LOAD_1      = 3'd2,
    ST_REQUEST     = 3'd3,
    ST_WAIT_ACCEPT = 3'd4,
    ST_WAIT_DONE   = 3'd5,
    ST_RESPOND     = 3'd6
  } state_t;

  localparam logic GRANT_N64 = 1'b0;
  localparam logic GRANT_USB = 1'b1;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1'b1);

  // On a tie the requester that did not win last time is served.
  function automatic logic pick_grant(input logic n64_req, input logic usb_req,
                                      input logic last_grant);
    logic pick;
    if (n64_req && usb_req) begin
      pick = (last_grant == GRANT_USB) ? GRANT_N64 : GRANT_USB;
    end else if (usb_req) begin
      pick = GRANT_USB;
    end else begin
      pick = GRANT_N64;
    end
    return pick;
  endfunction

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   grant_r;
  logic                   grant_next_s;
  logic                   grant_sel_s;
  logic                   last_grant_r;
  logic                   take_s;
  logic                   err_next_s;
  logic                   capture_s;
  logic [TIMEOUT_W-1:0]   cnt_r;
  logic [TIMEOUT_W-1:0]   cnt_next_s;
  logic [TIMEOUT_W-1:0]   cnt_inc_s;
  logic                   timeout_s;
  logic [7:0]             cmd_r;
  logic [7:0]             cmd_sel_s;
  logic [7:0]             cmd_next_s;
  logic [63:0]            arg_r;
  logic [63:0]            arg_sel_s;
  logic [63:0]            arg_next_s;
  logic [31:0]            wdata_r;
  logic [1:0]             data_write_r;
  logic                   cmd_request_r;
  logic                   busy_r;
  logic                   respond_s;
  logic                   n64_ack_r;
  logic                   n64_error_r;
  logic [63:0]            n64_rdata_r;
  logic                   usb_ack_r;
  logic                   usb_error_r;
  logic [63:0]            usb_rdata_r;

  assign cnt_inc_s = (&cnt_r) ? cnt_r : (cnt_r + TIMEOUT_W'(1'b1));
  assign timeout_s = (cnt_r == TIMEOUT_LAST);
  assign respond_s = (state_next_s == ST_RESPOND);

  // Candidate grant and the command/argument it would latch.
  always_comb begin
    grant_sel_s = pick_grant(bus.n64_req, bus.usb_req, last_grant_r);
    if (grant_sel_s == GRANT_USB) begin
      cmd_sel_s = bus.usb_cmd;
      arg_sel_s = bus.usb_wdata;
    end else begin
      cmd_sel_s = bus.n64_cmd;
      arg_sel_s = bus.n64_wdata;
    end
  end

  // Next-state logic for the mailbox transaction sequence.
  always_comb begin
    state_next_s = state_r;
    grant_next_s = grant_r;
    take_s       = 1'b0;
    err_next_s   = 1'b0;
    capture_s    = 1'b0;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.n64_req || bus.usb_req) begin
          take_s       = 1'b1;
          grant_next_s = grant_sel_s;
          if (!bus.cpu_ready) begin
            state_next_s = ST_RESPOND;
            err_next_s   = 1'b1;
          end else begin
            state_next_s = ST_LOAD_0;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD_0:  state_next_s = ST_LOAD_1;
      ST_LOAD_1:  state_next_s = ST_REQUEST;
      ST_REQUEST: begin
        state_next_s = ST_WAIT_ACCEPT;
        cnt_next_s   = '0;
      end
      ST_WAIT_ACCEPT: begin
        if (bus.cpu_busy) begin
          state_next_s = ST_WAIT_DONE;
          cnt_next_s   = '0;
        end else if (timeout_s || !bus.cpu_ready) begin
          state_next_s = ST_RESPOND;
          err_next_s   = 1'b1;
        end else begin
          cnt_next_s   = cnt_inc_s;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.cpu_busy) begin
          state_next_s = ST_RESPOND;
          capture_s    = 1'b1;
        end else if (timeout_s || !bus.cpu_ready) begin
          state_next_s = ST_RESPOND;
          err_next_s   = 1'b1;
        end else begin
          cnt_next_s   = cnt_inc_s;
        end
      end
      ST_RESPOND: state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
    cmd_next_s = take_s ? cmd_sel_s : cmd_r;
    arg_next_s = take_s ? arg_sel_s : arg_r;
  end

  // FSM state, grant bookkeeping and timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= GRANT_N64;
      last_grant_r <= GRANT_USB;
      cnt_r        <= '0;
      arg_r        <= 64'd0;
    end else begin
      state_r      <= state_next_s;
      grant_r      <= grant_next_s;
      last_grant_r <= take_s ? grant_next_s : last_grant_r;
      cnt_r        <= cnt_next_s;
      arg_r        <= arg_next_s;
    end
  end

  // Outputs are decoded from the next state so each one is a flop aligned with its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_r         <= 8'd0;
      wdata_r       <= 32'd0;
      data_write_r  <= 2'b00;
      cmd_request_r <= 1'b0;
      busy_r        <= 1'b0;
      n64_ack_r     <= 1'b0;
      n64_error_r   <= 1'b0;
      n64_rdata_r   <= 64'd0;
      usb_ack_r     <= 1'b0;
      usb_error_r   <= 1'b0;
      usb_rdata_r   <= 64'd0;
    end else begin
      cmd_r         <= cmd_next_s;
      busy_r        <= (state_next_s != ST_IDLE);
      cmd_request_r <= (state_next_s == ST_REQUEST);
      if (state_next_s == ST_LOAD_0) begin
        data_write_r <= 2'b01;
        wdata_r      <= arg_next_s[31:0];
      end else if (state_next_s == ST_LOAD_1) begin
        data_write_r <= 2'b10;
        wdata_r      <= arg_next_s[63:32];
      end else begin
        data_write_r <= 2'b00;
      end
      n64_ack_r   <= respond_s && (grant_next_s == GRANT_N64);
      n64_error_r <= respond_s && (grant_next_s == GRANT_N64) && err_next_s;
      usb_ack_r   <= respond_s && (grant_next_s == GRANT_USB);
      usb_error_r <= respond_s && (grant_next_s == GRANT_USB) && err_next_s;
      if (capture_s && (grant_r == GRANT_N64)) begin
        n64_rdata_r <= {bus.data_1, bus.data_0};
      end
      if (capture_s && (grant_r == GRANT_USB)) begin
        usb_rdata_r <= {bus.data_1, bus.data_0};
      end
    end
  end

  assign bus.cmd         = cmd_r;
  assign bus.wdata       = wdata_r;
  assign bus.data_write  = data_write_r;
  assign bus.cmd_request = cmd_request_r;
  assign bus.busy        = busy_r;
  assign bus.n64_ack     = n64_ack_r;
  assign bus.n64_error   = n64_error_r;
  assign bus.n64_rdata   = n64_rdata_r;
  assign bus.usb_ack     = usb_ack_r;
  assign bus.usb_error   = usb_error_r;
  assign bus.usb_rdata   = usb_rdata_r;

endmodule
